// File: rtl/alu_scan_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_scan_pkg
// Brief    : Mode encodings and active-low seven-segment glyphs for alu_scan_system.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_scan_pkg;

    localparam logic [3:0] MODE_ADD = 4'd0;
    localparam logic [3:0] MODE_SUB = 4'd1;
    localparam logic [3:0] MODE_MUL = 4'd2;
    localparam logic [3:0] MODE_AND = 4'd3;
    localparam logic [3:0] MODE_OR  = 4'd4;
    localparam logic [3:0] MODE_XOR = 4'd5;
    localparam logic [3:0] MODE_ACC = 4'd6;
    localparam logic [3:0] MODE_INC = 4'd7;
    localparam logic [3:0] MODE_SHL = 4'd8;
    localparam logic [3:0] MODE_SHR = 4'd9;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Bit order is {A,B,C,D,E,F,G}; a 0 lights the segment.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] glyph;
        case (nib)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b1100000;
            4'hC:    glyph = 7'b0110001;
            4'hD:    glyph = 7'b1000010;
            4'hE:    glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
        return glyph;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
//------------------------------------------------------------------------------
// Module   : btn_debounce
// Brief    : Two-flop synchroniser, stability counter and rising-edge pulse.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int                c_cnt_w    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_pulse;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_pulse  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                // Only a press is reported; an accepted release stays silent.
                r_stable <= r_sync2;
                r_pulse  <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/alu_scan_system.sv
//------------------------------------------------------------------------------
// Module   : alu_scan_system
// Brief    : Button-stepped registered ALU with a multiplexed hex display.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_scan_system #(
    parameter int WIDTH     = 6,
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           mode,
    input  logic                 inc,
    output logic [2*WIDTH-1:0]   result,
    output logic [DIGITS-1:0]    anode,
    output logic [6:0]           seg
);

    import alu_scan_pkg::*;

    localparam int                  RW          = 2 * WIDTH;
    localparam int                  c_idx_w     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int                  c_scan_w    = $clog2(SCAN_DIV);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(DIGITS - 1);
    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_DIV - 1);
    localparam logic [DIGITS-1:0]   c_one_hot0  = DIGITS'(1);

    logic                r_go_unused_guard;
    logic                w_go;
    logic [RW-1:0]       r_result;
    logic [RW-1:0]       w_a_ext;
    logic [RW-1:0]       w_b_ext;
    logic [RW-1:0]       w_alu;
    logic [c_scan_w-1:0] r_scan_cnt;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_idx_w-1:0]  w_next_idx;
    logic                w_tick;
    logic [DIGITS-1:0]   r_anode;
    logic [6:0]          r_seg;
    logic [6:0]          w_glyph [DIGITS];

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (reset),
        .i_btn   (inc),
        .o_pulse (w_go)
    );

    assign w_a_ext = {{WIDTH{1'b0}}, a};
    assign w_b_ext = {{WIDTH{1'b0}}, b};

    always_comb begin
        w_alu = r_result;
        case (mode)
            MODE_ADD: w_alu = w_a_ext + w_b_ext;
            MODE_SUB: w_alu = w_a_ext - w_b_ext;
            MODE_MUL: w_alu = w_a_ext * w_b_ext;
            MODE_AND: w_alu = w_a_ext & w_b_ext;
            MODE_OR:  w_alu = w_a_ext | w_b_ext;
            MODE_XOR: w_alu = w_a_ext ^ w_b_ext;
            MODE_ACC: w_alu = r_result + w_a_ext;
            MODE_INC: w_alu = r_result + RW'(1);
            MODE_SHL: w_alu = w_a_ext << b[2:0];
            MODE_SHR: w_alu = w_a_ext >> b[2:0];
            default:  w_alu = r_result;
        endcase
    end

    assign w_tick     = (r_scan_cnt == c_scan_last);
    assign w_next_idx = !w_tick ? r_idx :
                        (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);

    // Glyphs are built from the current result, so a digit refreshed in the
    // same cycle as an ALU update still shows the old value for one cycle.
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        if (4 * d + 4 <= RW) begin : g_full
            assign w_glyph[d] = hex_to_seg(r_result[4*d +: 4]);
        end else if (4 * d < RW) begin : g_part
            assign w_glyph[d] = hex_to_seg({{(4*d+4-RW){1'b0}}, r_result[RW-1:4*d]});
        end else begin : g_blank
            assign w_glyph[d] = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result   <= '0;
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_anode    <= ~c_one_hot0;
            r_seg      <= hex_to_seg(4'h0);
        end else begin
            if (w_go) begin
                r_result <= w_alu;
            end
            r_scan_cnt <= w_tick ? '0 : r_scan_cnt + c_scan_w'(1);
            r_idx      <= w_next_idx;
            r_anode    <= ~(c_one_hot0 << w_next_idx);
            r_seg      <= w_glyph[w_next_idx];
        end
    end

    assign r_go_unused_guard = 1'b0;
    assign result = r_result;
    assign anode  = r_anode;
    assign seg    = r_seg;

endmodule

`default_nettype wire
